// File: rtl/cmp_branch_ctrl.sv
// Conditional-branch sequencer and 8-bit PC behind the comparator.
// Optional taken/not-taken statistics are enabled by CMP_BRANCH_STATS_EN.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   pc_inc               advance pc by one this cycle
//   req_valid/req_ready  branch request handshake (ready only in IDLE)
//   req_a/req_b          compare operands
//   req_cond             00 eq, 01 lt, 10 gt, 11 unconditional
//   req_target           absolute branch target
//   opA/opB/sel          registered operands/select to the comparator
//   cmp_res              registered comparator result
//   pc                   program counter
//   br_done/br_taken     one-cycle resolve pulse and outcome
//   taken_cnt/nt_cnt     saturating statistics (0 when disabled)
module cmp_branch_ctrl #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pc_inc,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_cond,
  input  logic [7:0] req_target,
  output logic [7:0] opA,
  output logic [7:0] opB,
  output logic [1:0] sel,
  input  logic       cmp_res,
  output logic [7:0] pc,
  output logic       br_done,
  output logic       br_taken,
  output logic [7:0] taken_cnt,
  output logic [7:0] nt_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;

  logic [1:0] state;
  logic [7:0] target;
  logic       taken;
  logic       res_taken;
  logic       res_nt;
  logic [7:0] pc_nxt;

  assign req_ready = (state == IDLE);

  // Comparator yields 0 for sel=11, so unconditional is forced here.
  assign taken     = (sel == 2'b11) | cmp_res;
  assign res_taken = (state == RESOLVE) & taken;
  assign res_nt    = (state == RESOLVE) & ~taken;

  // A taken branch overrides a same-cycle increment.
  always_comb begin
    pc_nxt = pc;
    if (res_taken)
      pc_nxt = target;
    else if (pc_inc)
      pc_nxt = pc + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opA      <= 8'h00;
      opB      <= 8'h00;
      sel      <= 2'b00;
      target   <= 8'h00;
      pc       <= PC_RESET;
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_done  <= 1'b0;
      br_taken <= 1'b0;
      pc       <= pc_nxt;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            opA    <= req_a;
            opB    <= req_b;
            sel    <= req_cond;
            target <= req_target;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= RESOLVE;
        end
        RESOLVE: begin
          br_done  <= 1'b1;
          br_taken <= taken;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CMP_BRANCH_STATS_EN
  // Counts update on the resolve edge, alongside br_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= 8'h00;
      nt_cnt    <= 8'h00;
    end else begin
      if (res_taken && taken_cnt != 8'hFF)
        taken_cnt <= taken_cnt + 8'd1;
      if (res_nt && nt_cnt != 8'hFF)
        nt_cnt <= nt_cnt + 8'd1;
    end
  end
`else
  assign taken_cnt = 8'h00;
  assign nt_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_cmp_branch_ctrl.sv
// Directed bench for cmp_branch_ctrl with a behavioural comparator.
// Statistics expectations follow CMP_BRANCH_STATS_EN.
module tb_cmp_branch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pc_inc;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_cond;
  logic [7:0] req_target;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [1:0] sel;
  logic       cmp_res;
  logic [7:0] pc;
  logic       br_done;
  logic       br_taken;
  logic [7:0] taken_cnt;
  logic [7:0] nt_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_pc;

  cmp_branch_ctrl #(.PC_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
    .req_target(req_target),
    .opA(opA), .opB(opB), .sel(sel), .cmp_res(cmp_res),
    .pc(pc), .br_done(br_done), .br_taken(br_taken),
    .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered comparator; unconditional select returns 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmp_res <= 1'b0;
    else begin
      case (sel)
        2'b00:   cmp_res <= (opA == opB);
        2'b01:   cmp_res <= (opA < opB);
        2'b10:   cmp_res <= (opA > opB);
        default: cmp_res <= 1'b0;
      endcase
    end
  end

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request with pc_inc held over accept, issue and resolve edges.
  task automatic do_branch(input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] cond, input logic [7:0] tgt,
                           input logic inc, input logic exp_tk,
                           input logic [7:0] exp_pc);
    logic [7:0] p0;
    p0 = model_pc;
    @(negedge clk);
    chk("ready_idle", {7'd0, req_ready}, 8'd1);
    req_a = a; req_b = b; req_cond = cond; req_target = tgt;
    req_valid = 1'b1; pc_inc = inc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_issue", {7'd0, req_ready}, 8'd0);
    chk("opA", opA, a);
    chk("opB", opB, b);
    chk("sel", {6'd0, sel}, {6'd0, cond});
    chk("pc_step1", pc, p0 + {7'd0, inc});
    @(negedge clk);
    chk("ready_res", {7'd0, req_ready}, 8'd0);
    chk("done_early", {7'd0, br_done}, 8'd0);
    chk("pc_step2", pc, p0 + {6'd0, inc, 1'b0});
    @(negedge clk);
    pc_inc = 1'b0;
    chk("br_done", {7'd0, br_done}, 8'd1);
    chk("br_taken", {7'd0, br_taken}, {7'd0, exp_tk});
    chk("pc_final", pc, exp_pc);
    model_pc = exp_pc;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] cond;
    logic [7:0] tgt;
    logic       inc;
    logic       tk;
    logic [7:0] pc;
  } vec_t;

  vec_t v [12];
  int acc;
  logic [7:0] exp_tc;
  logic [7:0] exp_nc;
  logic [7:0] t8;

  initial begin
    v[0]  = '{8'h05, 8'h05, 2'b00, 8'h40, 1'b0, 1'b1, 8'h40};
    v[1]  = '{8'h03, 8'h09, 2'b01, 8'h55, 1'b0, 1'b1, 8'h55};
    v[2]  = '{8'h09, 8'h03, 2'b01, 8'h66, 1'b0, 1'b0, 8'h55};
    v[3]  = '{8'h09, 8'h03, 2'b10, 8'h77, 1'b0, 1'b1, 8'h77};
    v[4]  = '{8'h03, 8'h09, 2'b10, 8'h88, 1'b1, 1'b0, 8'h7A};
    v[5]  = '{8'h01, 8'h02, 2'b00, 8'h11, 1'b0, 1'b0, 8'h7A};
    v[6]  = '{8'h00, 8'h00, 2'b11, 8'h10, 1'b0, 1'b1, 8'h10};
    v[7]  = '{8'h03, 8'h09, 2'b10, 8'h80, 1'b1, 1'b0, 8'h13};
    v[8]  = '{8'hFF, 8'h00, 2'b11, 8'hFE, 1'b0, 1'b1, 8'hFE};
    v[9]  = '{8'h00, 8'h00, 2'b11, 8'h20, 1'b1, 1'b1, 8'h20};
    v[10] = '{8'hC8, 8'hC8, 2'b00, 8'hC8, 1'b0, 1'b1, 8'hC8};
    v[11] = '{8'hC8, 8'hC9, 2'b00, 8'h00, 1'b1, 1'b0, 8'hCB};

    rst_n = 1'b0; pc_inc = 1'b0; req_valid = 1'b0;
    req_a = 8'h00; req_b = 8'h00; req_cond = 2'b00; req_target = 8'h00;
    model_pc = 8'h00;
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ready", {7'd0, req_ready}, 8'd1);
    chk("rst_done", {7'd0, br_done}, 8'd0);
    chk("rst_tc", taken_cnt, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      do_branch(v[i].a, v[i].b, v[i].cond, v[i].tgt,
                v[i].inc, v[i].tk, v[i].pc);

    do_branch(8'h00, 8'h00, 2'b11, 8'hFF, 1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    chk("done_clear", {7'd0, br_done}, 8'd0);
    pc_inc = 1'b1;
    @(negedge clk);
    pc_inc = 1'b0;
    chk("pc_wrap", pc, 8'h00);
    model_pc = 8'h00;

    acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) chk("hold_opA0", opA, 8'h01);
      if (k == 1 || k == 2) chk("hold_opB0", opB, 8'hFE);
      if (k == 3) chk("hold_pc0", pc, 8'h30);
      if (k == 4 || k == 5) chk("hold_opA3", opA, 8'h04);
      if (req_ready) acc++;
      t8 = 8'(k + 1);
      req_a = t8; req_b = ~t8; req_cond = 2'b11;
      req_target = 8'h30 + 8'(k);
      req_valid = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_accepts", 8'(acc), 8'd2);
    chk("hold_done", {7'd0, br_done}, 8'd1);
    chk("hold_pc3", pc, 8'h33);
    model_pc = 8'h33;

`ifdef CMP_BRANCH_STATS_EN
    exp_tc = 8'd10; exp_nc = 8'd5;
`else
    exp_tc = 8'd0; exp_nc = 8'd0;
`endif
    chk("mid_tc", taken_cnt, exp_tc);
    chk("mid_nc", nt_cnt, exp_nc);

    @(negedge clk);
    req_a = 8'h07; req_b = 8'h07; req_cond = 2'b00;
    req_target = 8'h99; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 8'h00);
    chk("arst_opA", opA, 8'h00);
    chk("arst_opB", opB, 8'h00);
    chk("arst_sel", {6'd0, sel}, 8'h00);
    chk("arst_ready", {7'd0, req_ready}, 8'd1);
    chk("arst_done", {7'd0, br_done}, 8'd0);
    chk("arst_tc", taken_cnt, 8'h00);
    chk("arst_nc", nt_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_done", {7'd0, br_done}, 8'd0);
      chk("post_rst_pc", pc, 8'h00);
      chk("post_rst_ready", {7'd0, req_ready}, 8'd1);
    end
    model_pc = 8'h00;

    for (int i = 0; i < 300; i++) begin
      t8 = 8'(i);
      do_branch(t8, t8, 2'b00, t8, 1'b0, 1'b1, t8);
    end
    @(negedge clk);
`ifdef CMP_BRANCH_STATS_EN
    exp_tc = 8'hFF;
`else
    exp_tc = 8'h00;
`endif
    chk("sat_tc", taken_cnt, exp_tc);
    chk("sat_nc", nt_cnt, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
